// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter, 8N1 frames paced by an oversampled baud tick
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_fifo #(
   parameter int ADDR_W     = 4,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic [7:0] wr_data,
   input  logic       we,
   output logic       full,
   output logic       empty,
   output logic       overflow,
   output logic       tx,
   output logic       tx_busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [ADDR_W:0]  CNT_FULL  = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd4;
`endif

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   count_nxt;
   logic              push;
   logic              pop;
   logic [2:0]        state;
   logic [7:0]        shift;
   logic [CNT_W-1:0]  tick_cnt;
   logic [2:0]        bit_cnt;
   logic              bit_done;
`ifdef UART_TX_PARITY_EN
   logic              parity_bit;
`endif

   // A write while full is dropped even if the FSM pops in the same cycle.
   assign push     = we && !full;
   assign pop      = (state == ST_IDLE) && !empty;
   assign bit_done = tick && (tick_cnt == TICK_LAST);
   assign tx_busy  = (state != ST_IDLE);

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + (ADDR_W+1)'(1);
      else if (pop && !push)
         count_nxt = count - (ADDR_W+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + ADDR_W'(1);
         count    <= count_nxt;
         full     <= (count_nxt == CNT_FULL);
         empty    <= (count_nxt == '0);
         overflow <= we && full;
      end
   end

   // tx is registered and always loaded with the level of the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         tx       <= 1'b1;
         shift    <= '0;
         tick_cnt <= '0;
         bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         if (state != ST_IDLE && tick)
            tick_cnt <= bit_done ? '0 : tick_cnt + CNT_W'(1);
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  shift    <= mem[rd_ptr];
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
                  tx       <= 1'b0;
                  state    <= ST_START;
`ifdef UART_TX_PARITY_EN
                  parity_bit <= ^mem[rd_ptr];
`endif
               end
            end
            ST_START: begin
               if (bit_done) begin
                  tx    <= shift[0];
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     tx    <= parity_bit;
                     state <= ST_PARITY;
`else
                     tx    <= 1'b1;
                     state <= ST_STOP;
`endif
                  end else begin
                     shift   <= {1'b0, shift[7:1]};
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= shift[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_done) begin
                  tx    <= 1'b1;
                  state <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (bit_done)
                  state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo: frame-level line model plus directed cases
module tb_uart_tx_fifo;

   localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
   localparam logic [10:0] EXP35 = 11'b10001101010;
`else
   localparam int NBITS = 10;
   localparam logic [10:0] EXP35 = 11'b01001101010;
`endif
   localparam int FRAME_CYC = NBITS * OS;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       we = 1'b0;
   logic       full;
   logic       empty;
   logic       overflow;
   logic       tx;
   logic       tx_busy;

   int  checks = 0;
   int  errors = 0;
   bit  cmp_en = 1'b0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.ADDR_W(4), .OVERSAMPLE(OS)) dut (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .wr_data  (wr_data),
      .we       (we),
      .full     (full),
      .empty    (empty),
      .overflow (overflow),
      .tx       (tx),
      .tx_busy  (tx_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: byte queue for the FIFO, and the in-flight frame as a queue of line levels.
   byte unsigned m_q[$];
   logic         m_bits[$];
   int           m_tcnt;
   logic         m_ovf;
   logic         m_was_full;
   logic         m_do_pop;
   logic [7:0]   m_d;

   always @(posedge clk) begin
      if (reset) begin
         m_q.delete();
         m_bits.delete();
         m_tcnt = 0;
         m_ovf  = 1'b0;
      end else begin
         m_was_full = (m_q.size() == 16);
         m_do_pop   = (m_bits.size() == 0) && (m_q.size() != 0);
         m_ovf      = we && m_was_full;
         if (m_bits.size() != 0 && tick) begin
            m_tcnt++;
            if (m_tcnt == OS) begin
               m_tcnt = 0;
               void'(m_bits.pop_front());
            end
         end
         if (m_do_pop) begin
            m_d = m_q.pop_front();
            m_tcnt = 0;
            m_bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) m_bits.push_back(m_d[i]);
`ifdef UART_TX_PARITY_EN
            m_bits.push_back(^m_d);
`endif
            m_bits.push_back(1'b1);
         end
         if (we && !m_was_full) m_q.push_back(wr_data);
      end
   end

   logic exp_tx;
   always @(negedge clk) begin
      if (cmp_en) begin
         exp_tx = 1'b1;
         if (m_bits.size() != 0) exp_tx = m_bits[0];
         check("model_tx", tx, exp_tx);
         check("model_busy", tx_busy, m_bits.size() != 0);
         check("model_full", full, m_q.size() == 16);
         check("model_empty", empty, m_q.size() == 0);
         check("model_overflow", overflow, m_ovf);
      end
   end

   task automatic capture(input int max_wait, output int lat, output int len,
                          output logic [10:0] bits, output bit seen);
      logic [255:0] rec;
      lat = 0;
      len = 0;
      bits = '0;
      rec = '0;
      while (tx !== 1'b0 && lat < max_wait) begin
         step();
         lat++;
      end
      seen = (tx === 1'b0);
      if (!seen) return;
      while (tx_busy === 1'b1 && len < 256) begin
         rec[len] = tx;
         step();
         len++;
      end
      for (int k = 0; k < NBITS; k++) bits[k] = rec[k*OS + OS/2];
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int           lat;
   int           len;
   logic [10:0]  bits;
   bit           seen;
   int           cnt;
   int           bad;
   logic [7:0]   burst [3];

   initial begin
      burst[0] = 8'h31;
      burst[1] = 8'h32;
      burst[2] = 8'h0D;

      step();
      step();
      reset = 1'b0;
      cmp_en = 1'b1;
      check("reset_tx", tx, 1);
      check("reset_busy", tx_busy, 0);
      check("reset_full", full, 0);
      check("reset_empty", empty, 1);
      check("reset_overflow", overflow, 0);

      // Single byte 0x35, tick every cycle.
      tick = 1'b1;
      wr_data = 8'h35;
      we = 1'b1;
      step();
      we = 1'b0;
      check("single_empty_after_we", empty, 0);
      check("single_tx_high_at_we_edge", tx, 1);
      capture(10, lat, len, bits, seen);
      check("single_seen", seen, 1);
      check("single_we_to_fall_edges", lat, 1);
      check("single_busy_cycles", len, FRAME_CYC);
      check("single_bits", bits, EXP35);

      // Burst of three back-to-back writes.
      for (int i = 0; i < 3; i++) begin
         wr_data = burst[i];
         we = 1'b1;
         step();
      end
      we = 1'b0;
      for (int i = 0; i < 3; i++) begin
         capture(40, lat, len, bits, seen);
         check("burst_seen", seen, 1);
         if (i > 0) check("burst_idle_gap", lat, 1);
         check("burst_start", bits[0], 0);
         check("burst_data", bits[8:1], burst[i]);
         check("burst_stop", bits[NBITS-1], 1);
      end
      check("burst_empty_after", empty, 1);

      // Overflow with tick held low: the first byte is popped into the frozen frame.
      tick = 1'b0;
      for (int i = 0; i < 18; i++) begin
         wr_data = 8'(8'h40 + i);
         we = 1'b1;
         step();
         if (i == 15) check("ovf_not_full_yet", full, 0);
         if (i == 16) begin
            check("ovf_full", full, 1);
            check("ovf_no_pulse_yet", overflow, 0);
         end
         if (i == 17) check("ovf_pulse", overflow, 1);
      end
      we = 1'b0;
      step();
      check("ovf_pulse_one_cycle", overflow, 0);
      check("ovf_still_full", full, 1);
      tick = 1'b1;
      for (int i = 0; i < 17; i++) begin
         capture(40, lat, len, bits, seen);
         check("ovf_frame_seen", seen, 1);
         check("ovf_frame_data", bits[8:1], 8'(8'h40 + i));
      end
      capture(400, lat, len, bits, seen);
      check("ovf_dropped_never_sent", seen, 0);

      // Stall during data bit 2 of 0x5A (a low bit).
      wr_data = 8'h5A;
      we = 1'b1;
      step();
      we = 1'b0;
      step();
      cnt = 0;
      bad = 0;
      while (tx_busy === 1'b1 && cnt < 1000) begin
         if (cnt == 53) tick = 1'b0;
         if (cnt == 103) tick = 1'b1;
         if (cnt >= 53 && cnt < 103 && tx !== 1'b0) bad++;
         step();
         cnt++;
      end
      check("stall_tx_held", bad, 0);
      check("stall_busy_cycles", cnt, FRAME_CYC + 50);

      // Reset during data bit 3 with four bytes queued.
      for (int i = 0; i < 5; i++) begin
         wr_data = 8'(8'h61 + i);
         we = 1'b1;
         step();
      end
      we = 1'b0;
      repeat (67) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_mid_tx", tx, 1);
      check("rst_mid_empty", empty, 1);
      check("rst_mid_busy", tx_busy, 0);
      check("rst_mid_full", full, 0);
      bad = 0;
      repeat (300) begin
         if (tx !== 1'b1) bad++;
         step();
      end
      check("rst_mid_no_frames", bad, 0);

`ifdef UART_TX_PARITY_EN
      wr_data = 8'h07;
      we = 1'b1;
      step();
      we = 1'b0;
      capture(10, lat, len, bits, seen);
      check("par07_seen", seen, 1);
      check("par07_bit", bits[9], 1);
      check("par07_cycles", len, 176);
      wr_data = 8'h03;
      we = 1'b1;
      step();
      we = 1'b0;
      capture(10, lat, len, bits, seen);
      check("par03_seen", seen, 1);
      check("par03_bit", bits[9], 0);
`endif

      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
